// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker between the ITLB and DTLB miss
// paths. One walk at a time, round-robin on contention, result routed back
// to the requesting TLB only; an invalidate during a walk suppresses refill
// and fault, leaving only the done pulse.
module ptw_arbiter #(
  parameter int TAG_W = 27,
  parameter int PTE_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             invalidate_req,
  input  logic             itlb_req_valid,
  input  logic [63:0]      itlb_req_addr,
  output logic             itlb_req_ready,
  input  logic             dtlb_req_valid,
  input  logic [63:0]      dtlb_req_addr,
  input  logic             dtlb_req_is_store,
  output logic             dtlb_req_ready,
  output logic             ptw_req_valid,
  output logic [63:0]      ptw_req_addr,
  output logic             ptw_req_is_execute,
  output logic             ptw_req_is_store,
  input  logic             ptw_req_ready,
  input  logic             ptw_resp_valid,
  input  logic             ptw_resp_fault,
  input  logic [TAG_W-1:0] ptw_resp_tag,
  input  logic [PTE_W-1:0] ptw_resp_pte,
  output logic             itlb_done,
  output logic             dtlb_done,
  output logic             itlb_refill,
  output logic             dtlb_refill,
  output logic             itlb_fault,
  output logic             dtlb_fault,
  output logic [TAG_W-1:0] refill_tag,
  output logic [PTE_W-1:0] refill_pte
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WALK  = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic             stale_q, stale_d;
  logic [63:0]      addr_q, addr_d;
  logic             store_q, store_d;
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic             i_refill_q, i_refill_d;
  logic             d_refill_q, d_refill_d;
  logic             i_fault_q, i_fault_d;
  logic             d_fault_q, d_fault_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [PTE_W-1:0] pte_q, pte_d;

  logic grant_i, grant_d;
  logic stale_now;

  // Grant only in IDLE; on contention rr_q picks the winner. Masked while in
  // reset so no requester sees an acceptance that the reset discards.
  always_comb begin
    grant_i = !rst && (state_q == IDLE) && itlb_req_valid &&
              (!dtlb_req_valid || (rr_q == OWN_I));
    grant_d = !rst && (state_q == IDLE) && dtlb_req_valid &&
              (!itlb_req_valid || (rr_q == OWN_D));
  end

  // Next-state logic: latch the granted request, track staleness, and form
  // the completion pulses for the owner only.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    stale_d    = stale_q;
    addr_d     = addr_q;
    store_d    = store_q;
    tag_d      = tag_q;
    pte_d      = pte_q;
    i_done_d   = 1'b0;
    d_done_d   = 1'b0;
    i_refill_d = 1'b0;
    d_refill_d = 1'b0;
    i_fault_d  = 1'b0;
    d_fault_d  = 1'b0;
    // An invalidate arriving with the response still poisons that response.
    stale_now  = stale_q || invalidate_req;
    case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          owner_d = grant_d ? OWN_D : OWN_I;
          addr_d  = grant_d ? dtlb_req_addr : itlb_req_addr;
          store_d = grant_d && dtlb_req_is_store;
          stale_d = 1'b0;
          state_d = ISSUE;
          // The pointer only moves when there was actual contention.
          if (itlb_req_valid && dtlb_req_valid) begin
            rr_d = grant_d ? OWN_I : OWN_D;
          end
        end
      end
      ISSUE: begin
        if (invalidate_req) stale_d = 1'b1;
        if (ptw_req_ready) state_d = WALK;
      end
      WALK: begin
        if (invalidate_req) stale_d = 1'b1;
        if (ptw_resp_valid) begin
          state_d    = IDLE;
          tag_d      = ptw_resp_tag;
          pte_d      = ptw_resp_pte;
          i_done_d   = (owner_q == OWN_I);
          d_done_d   = (owner_q == OWN_D);
          i_refill_d = (owner_q == OWN_I) && !ptw_resp_fault && !stale_now;
          d_refill_d = (owner_q == OWN_D) && !ptw_resp_fault && !stale_now;
          i_fault_d  = (owner_q == OWN_I) && ptw_resp_fault && !stale_now;
          d_fault_d  = (owner_q == OWN_D) && ptw_resp_fault && !stale_now;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any walk in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      rr_q       <= OWN_I;
      stale_q    <= 1'b0;
      addr_q     <= '0;
      store_q    <= 1'b0;
      tag_q      <= '0;
      pte_q      <= '0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      i_refill_q <= 1'b0;
      d_refill_q <= 1'b0;
      i_fault_q  <= 1'b0;
      d_fault_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      stale_q    <= stale_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      tag_q      <= tag_d;
      pte_q      <= pte_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
      i_refill_q <= i_refill_d;
      d_refill_q <= d_refill_d;
      i_fault_q  <= i_fault_d;
      d_fault_q  <= d_fault_d;
    end
  end

  assign itlb_req_ready     = grant_i;
  assign dtlb_req_ready     = grant_d;
  assign ptw_req_valid      = (state_q == ISSUE);
  assign ptw_req_addr       = addr_q;
  assign ptw_req_is_execute = (state_q == ISSUE) && (owner_q == OWN_I);
  assign ptw_req_is_store   = store_q;
  assign itlb_done          = i_done_q;
  assign dtlb_done          = d_done_q;
  assign itlb_refill        = i_refill_q;
  assign dtlb_refill        = d_refill_q;
  assign itlb_fault         = i_fault_q;
  assign dtlb_fault         = d_fault_q;
  assign refill_tag         = tag_q;
  assign refill_pte         = pte_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: single walks, arbitration order, faults,
// stale walks, a stalled PTW and reset in the middle of a walk.
module tb_ptw_arbiter;

  localparam int TAG_W = 27;
  localparam int PTE_W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             invalidate_req;
  logic             itlb_req_valid;
  logic [63:0]      itlb_req_addr;
  logic             itlb_req_ready;
  logic             dtlb_req_valid;
  logic [63:0]      dtlb_req_addr;
  logic             dtlb_req_is_store;
  logic             dtlb_req_ready;
  logic             ptw_req_valid;
  logic [63:0]      ptw_req_addr;
  logic             ptw_req_is_execute;
  logic             ptw_req_is_store;
  logic             ptw_req_ready;
  logic             ptw_resp_valid;
  logic             ptw_resp_fault;
  logic [TAG_W-1:0] ptw_resp_tag;
  logic [PTE_W-1:0] ptw_resp_pte;
  logic             itlb_done, dtlb_done;
  logic             itlb_refill, dtlb_refill;
  logic             itlb_fault, dtlb_fault;
  logic [TAG_W-1:0] refill_tag;
  logic [PTE_W-1:0] refill_pte;

  // Bit map: 100 i_ready, 080 d_ready, 040 ptw_req_valid, 020 i_done,
  // 010 i_refill, 008 i_fault, 004 d_done, 002 d_refill, 001 d_fault.
  logic [8:0] flags;
  assign flags = {itlb_req_ready, dtlb_req_ready, ptw_req_valid,
                  itlb_done, itlb_refill, itlb_fault,
                  dtlb_done, dtlb_refill, dtlb_fault};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ptw_arbiter #(.TAG_W(TAG_W), .PTE_W(PTE_W)) dut (
    .clk(clk), .rst(rst), .invalidate_req(invalidate_req),
    .itlb_req_valid(itlb_req_valid), .itlb_req_addr(itlb_req_addr),
    .itlb_req_ready(itlb_req_ready),
    .dtlb_req_valid(dtlb_req_valid), .dtlb_req_addr(dtlb_req_addr),
    .dtlb_req_is_store(dtlb_req_is_store), .dtlb_req_ready(dtlb_req_ready),
    .ptw_req_valid(ptw_req_valid), .ptw_req_addr(ptw_req_addr),
    .ptw_req_is_execute(ptw_req_is_execute), .ptw_req_is_store(ptw_req_is_store),
    .ptw_req_ready(ptw_req_ready),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_fault(ptw_resp_fault),
    .ptw_resp_tag(ptw_resp_tag), .ptw_resp_pte(ptw_resp_pte),
    .itlb_done(itlb_done), .dtlb_done(dtlb_done),
    .itlb_refill(itlb_refill), .dtlb_refill(dtlb_refill),
    .itlb_fault(itlb_fault), .dtlb_fault(dtlb_fault),
    .refill_tag(refill_tag), .refill_pte(refill_pte)
  );

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    invalidate_req = 1'b0;
    itlb_req_valid = 1'b0; itlb_req_addr = '0;
    dtlb_req_valid = 1'b0; dtlb_req_addr = '0; dtlb_req_is_store = 1'b0;
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_fault = 1'b0;
    ptw_resp_tag = '0; ptw_resp_pte = '0;
    repeat (3) tick();
    rst = 1'b0;
    settle();
  endtask

  // Called in the cycle after acceptance; returns in the done-pulse cycle.
  task automatic run_walk(input string name, input bit own_d,
                          input logic [63:0] exp_addr, input bit exp_store,
                          input int ready_wait, input int resp_wait,
                          input bit fault, input bit inv_mid, input bit inv_at_resp,
                          input logic [TAG_W-1:0] tag, input logic [PTE_W-1:0] pte,
                          input logic [8:0] exp_done);
    for (int i = 0; i < ready_wait; i++) begin
      ptw_req_ready = 1'b0;
      settle();
      check_val({name, "_stall_flags"}, 64'(flags), 64'h040);
      check_val({name, "_stall_addr"}, ptw_req_addr, exp_addr);
      check_val({name, "_stall_exec"}, 64'(ptw_req_is_execute), 64'(!own_d));
      check_val({name, "_stall_store"}, 64'(ptw_req_is_store), 64'(exp_store));
      tick();
    end
    ptw_req_ready = 1'b1;
    settle();
    check_val({name, "_issue_flags"}, 64'(flags), 64'h040);
    check_val({name, "_issue_addr"}, ptw_req_addr, exp_addr);
    check_val({name, "_issue_exec"}, 64'(ptw_req_is_execute), 64'(!own_d));
    check_val({name, "_issue_store"}, 64'(ptw_req_is_store), 64'(exp_store));
    tick();
    ptw_req_ready = 1'b0;
    for (int i = 0; i < resp_wait - 1; i++) begin
      invalidate_req = inv_mid && (i == 0);
      settle();
      check_val({name, "_walk_flags"}, 64'(flags), 64'h000);
      tick();
    end
    invalidate_req = inv_at_resp;
    ptw_resp_valid = 1'b1;
    ptw_resp_fault = fault;
    ptw_resp_tag   = tag;
    ptw_resp_pte   = pte;
    tick();
    ptw_resp_valid = 1'b0;
    ptw_resp_fault = 1'b0;
    invalidate_req = 1'b0;
    settle();
    check_val({name, "_done_flags"}, 64'(flags), 64'(exp_done));
    check_val({name, "_done_tag"}, 64'(refill_tag), 64'(tag));
    check_val({name, "_done_pte"}, refill_pte, pte);
    $display("walk %s: owner=%s addr=0x%0h fault=%0d flags=0x%03h",
             name, own_d ? "D" : "I", exp_addr, fault, flags);
  endtask

  initial begin
    do_reset();
    check_val("reset_flags", 64'(flags), 64'h000);
    check_val("reset_tag", 64'(refill_tag), 64'h0);
    check_val("reset_pte", refill_pte, 64'h0);

    // Single ITLB miss, no fault.
    itlb_req_valid = 1'b1; itlb_req_addr = 64'h0000_0040_0000_1000;
    settle();
    check_val("t1_accept", 64'(flags), 64'h100);
    tick();
    itlb_req_valid = 1'b0;
    run_walk("t1", 1'b0, 64'h0000_0040_0000_1000, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0,
             27'h1ABCDEF, 64'h2000_04CF, 9'h030);
    tick();
    check_val("t1_pulse_end", 64'(flags), 64'h000);

    // Contention from reset: I first, D accepted on I's done cycle.
    do_reset();
    itlb_req_valid = 1'b1; itlb_req_addr = 64'h1000;
    dtlb_req_valid = 1'b1; dtlb_req_addr = 64'h2000; dtlb_req_is_store = 1'b1;
    settle();
    check_val("arb1_first_I", 64'(flags), 64'h100);
    tick();
    itlb_req_valid = 1'b0;
    run_walk("arb1_I", 1'b0, 64'h1000, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0,
             27'h11, 64'hA1, 9'h0B0);
    tick();
    dtlb_req_valid = 1'b0;
    run_walk("arb1_D", 1'b1, 64'h2000, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0,
             27'h22, 64'hA2, 9'h006);
    // Second round: pointer now favours D.
    tick();
    itlb_req_valid = 1'b1; itlb_req_addr = 64'h3000;
    dtlb_req_valid = 1'b1; dtlb_req_addr = 64'h4000; dtlb_req_is_store = 1'b1;
    settle();
    check_val("arb2_first_D", 64'(flags), 64'h080);
    tick();
    dtlb_req_valid = 1'b0;
    run_walk("arb2_D", 1'b1, 64'h4000, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0,
             27'h33, 64'hA3, 9'h106);
    tick();
    itlb_req_valid = 1'b0;
    run_walk("arb2_I", 1'b0, 64'h3000, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0,
             27'h44, 64'hA4, 9'h030);

    // DTLB load miss ending in a page fault.
    tick();
    dtlb_req_valid = 1'b1; dtlb_req_addr = 64'h5000; dtlb_req_is_store = 1'b0;
    settle();
    check_val("flt_accept", 64'(flags), 64'h080);
    tick();
    dtlb_req_valid = 1'b0;
    run_walk("flt", 1'b1, 64'h5000, 1'b0, 0, 2, 1'b1, 1'b0, 1'b0,
             27'h55, 64'hA5, 9'h005);

    // Invalidate mid-walk, then coincident with the response.
    tick();
    itlb_req_valid = 1'b1; itlb_req_addr = 64'h6000;
    settle();
    check_val("inv1_accept", 64'(flags), 64'h100);
    tick();
    itlb_req_valid = 1'b0;
    run_walk("inv_mid", 1'b0, 64'h6000, 1'b0, 0, 3, 1'b0, 1'b1, 1'b0,
             27'h66, 64'hA6, 9'h020);
    tick();
    itlb_req_valid = 1'b1; itlb_req_addr = 64'h7000;
    settle();
    check_val("inv2_accept", 64'(flags), 64'h100);
    tick();
    itlb_req_valid = 1'b0;
    run_walk("inv_resp", 1'b0, 64'h7000, 1'b0, 0, 2, 1'b0, 1'b0, 1'b1,
             27'h77, 64'hA7, 9'h020);

    // PTW stalls for 10 cycles while the ITLB waits.
    tick();
    dtlb_req_valid = 1'b1; dtlb_req_addr = 64'h8000; dtlb_req_is_store = 1'b1;
    settle();
    check_val("stall_accept", 64'(flags), 64'h080);
    tick();
    dtlb_req_valid = 1'b0;
    itlb_req_valid = 1'b1; itlb_req_addr = 64'h9000;
    run_walk("stall_D", 1'b1, 64'h8000, 1'b1, 10, 2, 1'b0, 1'b0, 1'b0,
             27'h88, 64'hA8, 9'h106);
    tick();
    itlb_req_valid = 1'b0;
    run_walk("stall_I", 1'b0, 64'h9000, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0,
             27'h99, 64'hA9, 9'h030);

    // Reset during WALK, then a stray response.
    tick();
    itlb_req_valid = 1'b1; itlb_req_addr = 64'hA000;
    settle();
    check_val("rst_accept", 64'(flags), 64'h100);
    tick();
    itlb_req_valid = 1'b0;
    ptw_req_ready = 1'b1;
    settle();
    check_val("rst_issue", 64'(flags), 64'h040);
    tick();
    ptw_req_ready = 1'b0;
    settle();
    check_val("rst_walk", 64'(flags), 64'h000);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check_val("rst_flags", 64'(flags), 64'h000);
    check_val("rst_tag", 64'(refill_tag), 64'h0);
    check_val("rst_pte", refill_pte, 64'h0);
    check_val("rst_addr", ptw_req_addr, 64'h0);
    check_val("rst_exec", 64'(ptw_req_is_execute), 64'h0);
    check_val("rst_store", 64'(ptw_req_is_store), 64'h0);
    ptw_resp_valid = 1'b1; ptw_resp_tag = 27'h5A5; ptw_resp_pte = 64'hDEAD;
    tick();
    ptw_resp_valid = 1'b0;
    settle();
    check_val("stray_flags", 64'(flags), 64'h000);
    check_val("stray_pte", refill_pte, 64'h0);
    tick();
    check_val("stray_flags2", 64'(flags), 64'h000);
    itlb_req_valid = 1'b1; itlb_req_addr = 64'hB000;
    settle();
    check_val("rst_idle_accept", 64'(flags), 64'h100);
    tick();
    itlb_req_valid = 1'b0;
    run_walk("post_rst", 1'b0, 64'hB000, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0,
             27'hBB, 64'hAB, 9'h030);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ptw_arbiter.md
# ptw_arbiter

Sequences the single shared page-table walker (PTW) between the instruction TLB and the data TLB miss paths inside the MMU. It accepts one miss request at a time with round-robin fairness, issues it to the PTW, holds the grant for the whole walk, and routes the result (refill or page fault) back to the requesting TLB only. A TLB invalidation during a walk marks the result stale, and the refill is suppressed.

## Interface
- TAG_W, 27: VPN tag width carried with the refill.
- PTE_W, 64: PTE width.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- invalidate_req  in  1  TLB invalidate (sfence.vma / satp write).
- itlb_req_valid  in  1  ITLB miss request; held until accepted.
- itlb_req_addr  in  64  ITLB miss virtual address.
- itlb_req_ready  out  1  ITLB request accepted this cycle.
- dtlb_req_valid  in  1  DTLB miss request; held until accepted.
- dtlb_req_addr  in  64  DTLB miss virtual address.
- dtlb_req_is_store  in  1  DTLB miss is a store.
- dtlb_req_ready  out  1  DTLB request accepted this cycle.
- ptw_req_valid  out  1  walk request to the PTW.
- ptw_req_addr  out  64  latched virtual address.
- ptw_req_is_execute  out  1  1 for an ITLB grant.
- ptw_req_is_store  out  1  latched store flag; 0 for an ITLB grant.
- ptw_req_ready  in  1  PTW accepts the request.
- ptw_resp_valid  in  1  walk finished (single-cycle pulse).
- ptw_resp_fault  in  1  walk ended in a page fault.
- ptw_resp_tag  in  TAG_W  refill tag.
- ptw_resp_pte  in  PTE_W  refill PTE.
- itlb_done, dtlb_done  out  1  walk complete for that requester (pulse).
- itlb_refill, dtlb_refill  out  1  TLB write enable (pulse).
- itlb_fault, dtlb_fault  out  1  page fault for that requester (pulse).
- refill_tag  out  TAG_W  registered copy of ptw_resp_tag.
- refill_pte  out  PTE_W  registered copy of ptw_resp_pte.

## Operation
- State machine: IDLE, ISSUE, WALK. Registers: owner (I/D), rr_ptr, stale, latched address and store flag.
- IDLE, grant selection:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by rr_ptr is granted, and rr_ptr then points to the other requester.
- IDLE, on a grant:
  - The granted req_ready is asserted combinationally that cycle.
  - Address, is_store (forced to 0 for ITLB) and owner are latched.
  - stale is cleared, and the state moves to ISSUE.
- ISSUE: ptw_req_valid=1 with the latched fields. When ptw_req_ready=1, the state moves to WALK.
- WALK: waits for ptw_resp_valid. On the response:
  - The owner's done pulses.
  - The owner's refill pulses only if !ptw_resp_fault and !stale.
  - The owner's fault pulses only if ptw_resp_fault and !stale.
  - refill_tag and refill_pte are registered.
  - The state returns to IDLE.
- The non-owner's ready, done, refill and fault outputs are never asserted.
- invalidate_req in ISSUE or WALK sets stale. invalidate_req in the same cycle as ptw_resp_valid counts as stale. invalidate_req in IDLE has no effect.
- Stale completion: only done pulses. The requester re-looks up, misses, and re-requests.
- ptw_resp_valid outside WALK is ignored.
- Reset:
  - State returns to IDLE; rr_ptr resets to I; stale and owner clear.
  - All outputs are 0: ready, done, refill, fault, ptw_req_valid, refill_tag and refill_pte.
  - Reset mid-walk abandons the walk; the PTW shares the same rst.

## Timing
- Accept at cycle T.
- ptw_req_valid is registered and first high at T+1. It stays high until the cycle ptw_req_ready=1, inclusive.
- ptw_resp_valid at cycle N (N ≥ ready cycle + 1). done, refill and fault are single-cycle pulses at N+1, when the state is already IDLE.
- A new request can be accepted at N+1, in the same cycle as the done pulse.
- Fastest turnaround: accept T, ready T+1, resp T+2, done T+3.
- At most one walk is outstanding; req_ready for either requester is 0 outside IDLE.

## Test plan
- Single ITLB miss, addr 0x0000_0040_0000_1000, ptw_req_ready immediately, resp 3 cycles later with no fault, tag 0x1ABCDEF, pte 0x2000_04CF. Expected:
  - ptw_req_addr matches, is_execute=1, is_store=0.
  - itlb_done and itlb_refill pulse one cycle after resp, with refill_pte=0x2000_04CF.
  - No dtlb_* activity.
- ITLB and DTLB (store) valid in the same cycle, from reset. Expected:
  - ITLB is granted first; DTLB is accepted in the cycle its done pulse returns.
  - Repeating the simultaneous requests gives the order D, I, D, I.
- DTLB load miss with ptw_resp_fault=1. Expected: dtlb_done and dtlb_fault pulse, dtlb_refill=0, itlb_* all 0.
- invalidate_req pulsed mid-WALK, then resp with no fault. Expected: itlb_done=1, itlb_refill=0. Repeat with invalidate_req in the same cycle as resp: same result.
- ptw_req_ready held low for 10 cycles. Expected: ptw_req_valid and its fields are stable for all 10 cycles, and itlb_req_ready and dtlb_req_ready stay 0 throughout.
- rst asserted during WALK, then a stray ptw_resp_valid after reset. Expected: every output is 0 and the state is IDLE after reset, and the stray response produces no done, refill or fault pulse.
